// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modexp_ctrl exponentiation controller.
// Final Montgomery-to-normal conversion is selected by MODEXP_FINAL_CONV_EN.
package modexp_pkg;

    localparam int DATA_W_DEF = 1024;
    localparam int E_W_DEF    = 1024;
    localparam int CNT_W_DEF  = $clog2(E_W_DEF);

    // Bit-index counter width for a given exponent width; never below one bit.
    function automatic int cnt_w(input int e_w);
        return (e_w > 1) ? $clog2(e_w) : 1;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_NEXT,
        S_CONV_ISSUE,
        S_CONV_WAIT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/modexp_mont_if.sv
// Multiplier completion tracker: a done level is only accepted after it has
// been observed low since the last mont_start, so stale done levels are ignored.
module modexp_mont_if
    import modexp_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic arm_i,
    input  logic mont_done_i,
    output logic accept_o
);

    logic armed_q, armed_d;
    logic low_seen_q, low_seen_d;

    always_comb begin
        accept_o   = armed_q & low_seen_q & mont_done_i;
        armed_d    = armed_q;
        low_seen_d = low_seen_q;
        if (arm_i) begin
            armed_d    = 1'b1;
            low_seen_d = 1'b0;
        end else if (accept_o) begin
            armed_d    = 1'b0;
        end else if (armed_q && !mont_done_i) begin
            low_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            armed_q    <= 1'b0;
            low_seen_q <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            low_seen_q <= low_seen_d;
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation controller driving an external
// Montgomery multiplier. MODEXP_FINAL_CONV_EN adds a final Mont(A,1) conversion.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int E_W    = E_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [E_W-1:0]    in_e,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_rmodm,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              mont_start,
    output logic [DATA_W-1:0] mont_a,
    output logic [DATA_W-1:0] mont_b,
    output logic [DATA_W-1:0] mont_m,
    input  logic [DATA_W-1:0] mont_result,
    input  logic              mont_done
);

    localparam int              CNT_W   = cnt_w(E_W);
    localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(E_W - 1);

    state_t              state_q;
    logic [DATA_W-1:0]   x_q;
    logic [DATA_W-1:0]   a_q;
    logic [E_W-1:0]      e_q;
    logic [CNT_W-1:0]    idx_q;
    logic [DATA_W-1:0]   result_q;
    logic                done_q;
    logic                mont_start_q;
    logic [DATA_W-1:0]   mont_a_q;
    logic [DATA_W-1:0]   mont_b_q;
    logic [DATA_W-1:0]   mont_m_q;
    logic                accept;

    assign result     = result_q;
    assign done       = done_q;
    assign mont_start = mont_start_q;
    assign mont_a     = mont_a_q;
    assign mont_b     = mont_b_q;
    assign mont_m     = mont_m_q;

    modexp_mont_if u_mont_if (
        .clk         (clk),
        .resetn      (resetn),
        .arm_i       (mont_start_q),
        .mont_done_i (mont_done),
        .accept_o    (accept)
    );

    // Outputs are registered on entry to each state, so mont_start and done
    // are high exactly during the ISSUE and FINISH cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            a_q          <= '0;
            e_q          <= '0;
            idx_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            mont_start_q <= 1'b0;
            mont_a_q     <= '0;
            mont_b_q     <= '0;
            mont_m_q     <= '0;
        end else begin
            mont_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q          <= in_x;
                        e_q          <= in_e;
                        mont_m_q     <= in_m;
                        a_q          <= in_rmodm;
                        idx_q        <= IDX_MSB;
                        mont_a_q     <= in_rmodm;
                        mont_b_q     <= in_rmodm;
                        mont_start_q <= 1'b1;
                        state_q      <= S_SQ_ISSUE;
                    end
                end
                S_SQ_ISSUE: state_q <= S_SQ_WAIT;
                S_SQ_WAIT: begin
                    if (accept) begin
                        a_q <= mont_result;
                        if (e_q[idx_q]) begin
                            mont_a_q     <= mont_result;
                            mont_b_q     <= x_q;
                            mont_start_q <= 1'b1;
                            state_q      <= S_MUL_ISSUE;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_MUL_ISSUE: state_q <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (accept) begin
                        a_q     <= mont_result;
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx_q == '0) begin
`ifdef MODEXP_FINAL_CONV_EN
                        mont_a_q     <= a_q;
                        mont_b_q     <= {{(DATA_W-1){1'b0}}, 1'b1};
                        mont_start_q <= 1'b1;
                        state_q      <= S_CONV_ISSUE;
`else
                        result_q <= a_q;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
`endif
                    end else begin
                        idx_q        <= idx_q - 1'b1;
                        mont_a_q     <= a_q;
                        mont_b_q     <= a_q;
                        mont_start_q <= 1'b1;
                        state_q      <= S_SQ_ISSUE;
                    end
                end
`ifdef MODEXP_FINAL_CONV_EN
                S_CONV_ISSUE: state_q <= S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (accept) begin
                        a_q      <= mont_result;
                        result_q <= mont_result;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end
                end
`endif
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural Montgomery multiplier.
module tb_modexp_ctrl;

    localparam int DW = 1024;
    localparam int EW = 8;
`ifdef MODEXP_FINAL_CONV_EN
    localparam int CONV_OPS = 1;
`else
    localparam int CONV_OPS = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_x = '0;
    logic [EW-1:0] in_e = '0;
    logic [DW-1:0] in_m = '0;
    logic [DW-1:0] in_rmodm = '0;
    logic [DW-1:0] result;
    logic          done;
    logic          mont_start;
    logic [DW-1:0] mont_a, mont_b, mont_m;
    logic [DW-1:0] mont_result = '0;
    logic          mont_done = 1'b0;

    always #5 clk = ~clk;

    modexp_ctrl #(.DATA_W(DW), .E_W(EW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .in_x        (in_x),
        .in_e        (in_e),
        .in_m        (in_m),
        .in_rmodm    (in_rmodm),
        .result      (result),
        .done        (done),
        .mont_start  (mont_start),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .mont_m      (mont_m),
        .mont_result (mont_result),
        .mont_done   (mont_done)
    );

    typedef struct {
        logic [DW-1:0] res;
        int            starts;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_starts = 0;
    int   hold_len = 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got ...%h required ...%h (low 128 bits)", name, act[127:0], req[127:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ---------------- reference arithmetic (normal domain, plain modulo) ----
    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
        logic [2*DW-1:0] p;
        logic [2*DW-1:0] mm;
        p  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        mm = {{DW{1'b0}}, m};
        p  = p % mm;
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] to_mont(input logic [DW-1:0] x, input logic [DW-1:0] m);
        logic [2*DW-1:0] p;
        logic [2*DW-1:0] mm;
        p  = {x, {DW{1'b0}}};
        mm = {{DW{1'b0}}, m};
        p  = p % mm;
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] r_mod(input logic [DW-1:0] m);
        logic [2*DW-1:0] p;
        logic [2*DW-1:0] mm;
        p     = '0;
        p[DW] = 1'b1;
        mm    = {{DW{1'b0}}, m};
        p     = p % mm;
        return p[DW-1:0];
    endfunction

    // x^e by repeated multiplication, then mapped to the domain the DUT reports.
    function automatic logic [DW-1:0] model_result(input logic [DW-1:0] x_n, input int e,
                                                   input logic [DW-1:0] m);
        logic [DW-1:0] pw;
        pw = 1;
        for (int j = 0; j < e; j++) pw = mulmod(pw, x_n, m);
`ifdef MODEXP_FINAL_CONV_EN
        return pw;
`else
        return mulmod(pw, r_mod(m), m);
`endif
    endfunction

    // Behavioural Montgomery product a*b*2^-DW mod m (the external multiplier).
    function automatic logic [DW-1:0] mont_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] m);
        logic [DW+1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_mod();
        logic [DW-1:0] v;
        v         = rand_wide();
        v[0]      = 1'b1;
        v[DW-1]   = 1'b1;
        return v;
    endfunction

    // ---------------- multiplier model ----------------
    initial begin : mult_model
        logic [DW-1:0] ma, mb, mm;
        int busy, cnt, drop, hold;
        busy = 0; cnt = 0; drop = 0; hold = 0;
        ma = '0; mb = '0; mm = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                busy = 0; drop = 0; hold = 0;
                mont_done = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) mont_done = 1'b0;
                end
                if (drop > 0) begin
                    drop--;
                    if (drop == 0) begin
                        mont_done = 1'b0;
                        hold = 0;
                    end
                end
                if (busy != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy        = 0;
                        mont_result = mont_mul(ma, mb, mm);
                        mont_done   = 1'b1;
                        hold        = hold_len;
                    end
                end
                if (mont_start) begin
                    busy = 1;
                    cnt  = $urandom_range(6, 3);
                    drop = 2;
                    ma = mont_a; mb = mont_b; mm = mont_m;
                    n_starts++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #2;
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required no pending request");
                end else begin
                    ex = sbq.pop_front();
                    check("result", result, ex.res);
                    check_int("mont_start_count", n_starts, ex.starts);
                end
                n_starts = 0;
                @(posedge clk);
                #2;
                check_int("done_one_cycle", int'(done), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] cur_xm;

    task automatic issue(input logic [DW-1:0] x_n, input logic [EW-1:0] e, input logic [DW-1:0] m);
        exp_t ex;
        @(negedge clk);
        cur_xm    = to_mont(x_n, m);
        in_x      = cur_xm;
        in_e      = e;
        in_m      = m;
        in_rmodm  = r_mod(m);
        start     = 1'b1;
        ex.res    = model_result(x_n, int'(e), m);
        ex.starts = EW + $countones(e) + CONV_OPS;
        sbq.push_back(ex);
        @(negedge clk);
        start    = 1'b0;
        in_x     = rand_wide();
        in_e     = EW'($urandom);
        in_m     = rand_wide();
        in_rmodm = rand_wide();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got %0d pending required 0", sbq.size());
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_run(input logic [EW-1:0] e);
        logic [DW-1:0] m;
        m = rand_mod();
        issue(rand_wide() % m, e, m);
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, result, '0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_mont_start"}, int'(mont_start), 0);
        check({tag, "_mont_a"}, mont_a, '0);
        check({tag, "_mont_b"}, mont_b, '0);
        check({tag, "_mont_m"}, mont_m, '0);
    endtask

    initial begin : stim
        logic [DW-1:0] m;
        logic [DW-1:0] x_n;
        int k;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        rand_run(8'h00);
        rand_run(8'h05);

        m = '1;
        m = m - 104;
        issue(1024'h1234, 8'h01, m);
        wait_idle();

        rand_run(8'hFF);
        rand_run(8'h80);

        hold_len = 5;
        rand_run(8'h05);
        rand_run(EW'($urandom));
        rand_run(EW'($urandom));

        // A second start while busy must not disturb the registered operands.
        m   = rand_mod();
        x_n = rand_wide() % m;
        issue(x_n, 8'hA6, m);
        k = 0;
        while (!mont_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_int("first_mont_start_seen", int'(mont_start), 1);
        @(negedge clk);
        in_e  = 8'h59;
        in_x  = rand_wide();
        in_m  = rand_wide();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset while a multiplication is outstanding.
        hold_len = 1;
        m   = rand_mod();
        x_n = rand_wide() % m;
        issue(x_n, 8'h05, m);
        k = 0;
        while (!(mont_start && mont_b == cur_xm && mont_a != mont_b) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_int("mul_issue_seen", int'(mont_start), 1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_zero_outputs("midrst");
        sbq.delete();
        n_starts = 0;
        repeat (2) @(negedge clk);
        rand_run(8'h05);

        for (int r = 0; r < 3; r++) rand_run(EW'($urandom));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
